// File: rtl/nios_core_mem_fill_pkg.sv
// Shared types and constants for the memory fill/verify initiator.
package nios_core_mem_fill_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 14;
    localparam int unsigned DEFAULT_DATA_W = 32;

    localparam logic PATTERN_CONST = 1'b0;
    localparam logic PATTERN_INCR  = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StCheck,
        StDone
    } state_e;

endpackage

// File: rtl/nios_core_mem_fill_pattern.sv
// Combinational fill-pattern generator: constant seed or seed plus word index.
module nios_core_mem_fill_pattern
    import nios_core_mem_fill_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned IDX_W  = DEFAULT_ADDR_W + 1
) (
    input  logic [DATA_W-1:0] seed,
    input  logic [IDX_W-1:0]  index,
    input  logic              mode,
    output logic [DATA_W-1:0] word
);

    always_comb begin
        word = seed;
        if (mode == PATTERN_INCR) begin
            word = seed + DATA_W'(index);
        end
    end

endmodule

// File: rtl/nios_core_mem_fill_master.sv
// Avalon-MM fill/self-test initiator for the on-chip memory s2 port.
// Define NIOS_CORE_MEM_FILL_VERIFY_EN to build the read-back compare path.
module nios_core_mem_fill_master
    import nios_core_mem_fill_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    input  logic                pattern_mode,
    input  logic [DATA_W-1:0]   seed,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_W-1:0]   err_addr,
    output logic [DATA_W-1:0]   err_data
);

    localparam int unsigned IDX_W = ADDR_W + 1;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                mode_q, mode_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic                last;
    logic                acc_d;
    logic                wr_d;
    logic                accept;
    logic [DATA_W-1:0]   wr_word;

    assign last      = (idx_q == count_q - IDX_W'(1));
    assign accept    = (state_q == StIdle) && start;
    assign mem_clken = ~reset;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        base_d  = base_q;
        mode_d  = mode_q;
        seed_d  = seed_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d  = base_addr;
                    count_d = word_count;
                    mode_d  = pattern_mode;
                    seed_d  = seed;
                    idx_d   = '0;
                    state_d = (word_count == '0) ? StDone : StWrite;
                end
            end
            StWrite: begin
                idx_d = idx_q + IDX_W'(1);
                if (last) begin
                    idx_d = '0;
`ifdef NIOS_CORE_MEM_FILL_VERIFY_EN
                    state_d = StRead;
`else
                    state_d = StDone;
`endif
                end
            end
            StRead: begin
                idx_d = idx_q + IDX_W'(1);
                if (last) begin
                    idx_d   = '0;
                    state_d = StCheck;
                end
            end
            StCheck: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign acc_d = (state_d == StWrite) || (state_d == StRead);
    assign wr_d  = (state_d == StWrite);

    // Write data is generated from next-state values so the bus outputs can be registered.
    nios_core_mem_fill_pattern #(
        .DATA_W(DATA_W),
        .IDX_W (IDX_W)
    ) u_wr_pattern (
        .seed (seed_d),
        .index(idx_d),
        .mode (mode_d),
        .word (wr_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            idx_q          <= '0;
            count_q        <= '0;
            base_q         <= '0;
            mode_q         <= 1'b0;
            seed_q         <= '0;
            mem_address    <= '0;
            mem_byteenable <= '0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            count_q        <= count_d;
            base_q         <= base_d;
            mode_q         <= mode_d;
            seed_q         <= seed_d;
            mem_address    <= acc_d ? base_d + idx_d[ADDR_W-1:0] : '0;
            mem_byteenable <= acc_d ? '1 : '0;
            mem_chipselect <= acc_d;
            mem_write      <= wr_d;
            mem_writedata  <= wr_d ? wr_word : '0;
            busy           <= (state_d != StIdle);
            done           <= (state_d == StDone);
        end
    end

`ifdef NIOS_CORE_MEM_FILL_VERIFY_EN
    logic              cmp_valid_q;
    logic [IDX_W-1:0]  cmp_idx_q;
    logic [ADDR_W-1:0] cmp_addr_q;
    logic [DATA_W-1:0] exp_word;

    nios_core_mem_fill_pattern #(
        .DATA_W(DATA_W),
        .IDX_W (IDX_W)
    ) u_exp_pattern (
        .seed (seed_q),
        .index(cmp_idx_q),
        .mode (mode_q),
        .word (exp_word)
    );

    // Read k's address is on the bus while state_q is StRead; its data returns next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp_valid_q <= 1'b0;
            cmp_idx_q   <= '0;
            cmp_addr_q  <= '0;
            error       <= 1'b0;
            err_addr    <= '0;
            err_data    <= '0;
        end else begin
            cmp_valid_q <= (state_q == StRead);
            cmp_idx_q   <= idx_q;
            cmp_addr_q  <= mem_address;
            if (accept) begin
                error    <= 1'b0;
                err_addr <= '0;
                err_data <= '0;
            end else if (cmp_valid_q && !error && (mem_readdata != exp_word)) begin
                error    <= 1'b1;
                err_addr <= cmp_addr_q;
                err_data <= mem_readdata;
            end
        end
    end
`else
    logic unused_verify;
    assign unused_verify = ^{mem_readdata, accept};
    assign error    = 1'b0;
    assign err_addr = '0;
    assign err_data = '0;
`endif

endmodule

// File: tb/tb_nios_core_mem_fill_master.sv
// Self-checking bench: directed table, hand sequences and random commands vs a cycle model.
module tb_nios_core_mem_fill_master;

`ifdef NIOS_CORE_MEM_FILL_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] base_addr;
    logic [14:0] word_count;
    logic        pattern_mode;
    logic [31:0] seed;
    logic [13:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata = '0;
    logic        busy;
    logic        done;
    logic        error;
    logic [13:0] err_addr;
    logic [31:0] err_data;

    int vectors = 0;
    int miscompares = 0;

    nios_core_mem_fill_master dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .word_count    (word_count),
        .pattern_mode  (pattern_mode),
        .seed          (seed),
        .mem_address   (mem_address),
        .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect),
        .mem_write     (mem_write),
        .mem_writedata (mem_writedata),
        .mem_clken     (mem_clken),
        .mem_readdata  (mem_readdata),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_addr      (err_addr),
        .err_data      (err_data)
    );

    always #5 clk = ~clk;

    // Memory model with optional read-side corruption at two fixed words.
    logic [31:0] mem [0:16383];
    bit corrupt_on = 1'b0;

    function automatic bit is_bad(input int a);
        return corrupt_on && (a == 'h12 || a == 'h14);
    endfunction

    function automatic logic [31:0] bad_val(input int a);
        return (a == 'h12) ? 32'hDEADBEEF : 32'h0BADF00D;
    endfunction

    always @(posedge clk) begin
        if (mem_chipselect && mem_write) mem[mem_address] <= mem_writedata;
        if (mem_chipselect && !mem_write)
            mem_readdata <= is_bad(int'(mem_address)) ? bad_val(int'(mem_address))
                                                      : mem[mem_address];
    end

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        cs;
        logic        wr;
        logic [3:0]  be;
        logic [13:0] addr;
        logic [31:0] wdata;
        logic        clken;
        logic        err;
        logic [13:0] ea;
        logic [31:0] ed;
    } obs_t;

    function automatic obs_t sample();
        obs_t o;
        o.busy  = busy;          o.done  = done;
        o.cs    = mem_chipselect; o.wr    = mem_write;
        o.be    = mem_byteenable; o.addr  = mem_address;
        o.wdata = mem_writedata;  o.clken = mem_clken;
        o.err   = error;          o.ea    = err_addr;
        o.ed    = err_data;
        return o;
    endfunction

    task automatic check(input obs_t a, input obs_t e, input string name);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic check32(input logic [31:0] a, input logic [31:0] e, input string name);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] s, input bit m, input int k);
        return m ? s + 32'(k) : s;
    endfunction

    // Expected bus/status view for cycle t after the start edge.
    function automatic obs_t expect_at(input int base, input int n, input bit m,
                                       input logic [31:0] s, input int fk, input int t);
        obs_t e;
        int total;
        total   = (n == 0) ? 1 : (VERIFY ? 2 * n + 2 : n + 1);
        e       = '0;
        e.clken = 1'b1;
        if (t <= total) begin
            e.busy = 1'b1;
            e.done = (t == total);
        end
        if (t >= 1 && t <= n) begin
            e.cs = 1'b1; e.wr = 1'b1; e.be = 4'hF;
            e.addr  = 14'((base + t - 1) % 16384);
            e.wdata = pat(s, m, t - 1);
        end else if (VERIFY && t > n && t <= 2 * n) begin
            e.cs = 1'b1; e.be = 4'hF;
            e.addr = 14'((base + t - n - 1) % 16384);
        end
        if (VERIFY && fk >= 0 && t >= n + 3 + fk) begin
            e.err = 1'b1;
            e.ea  = 14'((base + fk) % 16384);
            e.ed  = bad_val((base + fk) % 16384);
        end
        return e;
    endfunction

    // Caller enters just after a negedge; task returns just after a negedge, idle.
    task automatic run_cmd(input int id, input int base, input int n, input bit m,
                           input logic [31:0] s, input int glitch, output int done_cyc);
        int   total;
        int   fk;
        obs_t e;
        obs_t a;
        fk = -1;
        for (int k = 0; k < n; k++)
            if (fk < 0 && is_bad((base + k) % 16384)) fk = k;
        total    = (n == 0) ? 1 : (VERIFY ? 2 * n + 2 : n + 1);
        done_cyc = -1;
        base_addr = 14'(base); word_count = 15'(n); pattern_mode = m; seed = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; base_addr = ~base_addr; word_count = 15'd3;
        pattern_mode = ~m; seed = ~s;
        for (int t = 1; t <= total + 1; t++) begin
            @(negedge clk);
            a = sample();
            if (a.done && done_cyc < 0) done_cyc = t;
            e = expect_at(base, n, m, s, fk, t);
            check(a, e, $sformatf("cmd%0d cyc%0d", id, t));
            start = 1'b0;
            if (glitch == t && t < total) begin
                start = 1'b1; base_addr = 14'($urandom); word_count = 15'd1;
                pattern_mode = ~m; seed = $urandom;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_mem(input int id, input int base, input int n, input bit m,
                             input logic [31:0] s);
        for (int k = 0; k < n; k++)
            check32(mem[(base + k) % 16384], pat(s, m, k), $sformatf("cmd%0d mem%0d", id, k));
    endtask

    typedef struct {
        int          base;
        int          n;
        bit          mode;
        logic [31:0] seed;
        bit          corrupt;
        int          done_v;
        int          done_nv;
        bit          err;
        logic [13:0] ea;
        logic [31:0] ed;
    } row_t;

    row_t rows [5];

    initial begin
        obs_t e;
        int   dc;
        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        pattern_mode = 1'b0; seed = '0;
        for (int i = 0; i < 16384; i++) mem[i] = '0;

        rows[0] = '{'h0000, 4, 1'b1, 32'h00000100, 1'b0, 10, 5, 1'b0, 14'h0,  32'h0};
        rows[1] = '{'h3FFE, 4, 1'b0, 32'hA5A5A5A5, 1'b0, 10, 5, 1'b0, 14'h0,  32'h0};
        rows[2] = '{'h0010, 8, 1'b1, 32'h00000055, 1'b1, 18, 9, 1'b1, 14'h12, 32'hDEADBEEF};
        rows[3] = '{'h0100, 0, 1'b0, 32'h00001234, 1'b0, 1,  1, 1'b0, 14'h0,  32'h0};
        rows[4] = '{'h3FFF, 3, 1'b1, 32'hFFFFFFFE, 1'b0, 8,  4, 1'b0, 14'h0,  32'h0};

        #3;
        check(sample(), '0, "reset state");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        e = '0; e.clken = 1'b1;
        check(sample(), e, "idle after reset");

        for (int r = 0; r < 5; r++) begin
            corrupt_on = rows[r].corrupt;
            run_cmd(r, rows[r].base, rows[r].n, rows[r].mode, rows[r].seed, 0, dc);
            check32(32'(dc), 32'(VERIFY ? rows[r].done_v : rows[r].done_nv),
                    $sformatf("row%0d done cycle", r));
            e = '0; e.clken = 1'b1;
            e.err = rows[r].err & VERIFY;
            e.ea  = VERIFY ? rows[r].ea : 14'h0;
            e.ed  = VERIFY ? rows[r].ed : 32'h0;
            check(sample(), e, $sformatf("row%0d final status", r));
            check_mem(r, rows[r].base, rows[r].n, rows[r].mode, rows[r].seed);
        end

        // start pulsed during the write phase must not disturb the command.
        corrupt_on = 1'b0;
        run_cmd(10, 'h200, 6, 1'b1, 32'h12345678, 3, dc);
        check_mem(10, 'h200, 6, 1'b1, 32'h12345678);

        // Reset mid-read abandons the command without a done pulse.
        base_addr = 14'h20; word_count = 15'd4; pattern_mode = 1'b1; seed = 32'h77;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1 check(sample(), '0, "reset async");
        @(posedge clk);
        #1 check(sample(), '0, "reset held");
        @(negedge clk);
        reset = 1'b0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            e = '0; e.clken = 1'b1;
            check(sample(), e, $sformatf("post reset idle %0d", t));
        end
        run_cmd(11, 'h40, 5, 1'b0, 32'hCAFEF00D, 0, dc);
        check_mem(11, 'h40, 5, 1'b0, 32'hCAFEF00D);

        for (int r = 0; r < 40; r++) begin
            int          b;
            int          n;
            bit          m;
            logic [31:0] s;
            n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
            case ($urandom_range(0, 2))
                0:       b = int'($urandom_range(0, 31));
                1:       b = int'($urandom_range(16370, 16383));
                default: b = int'($urandom_range(0, 16383));
            endcase
            m = 1'($urandom_range(0, 1));
            s = $urandom;
            corrupt_on = 1'($urandom_range(0, 1));
            run_cmd(100 + r, b, n, m, s, 0, dc);
            check_mem(100 + r, b, n, m, s);
        end

        // Full 16384-word command wrapping the whole address space.
        corrupt_on = 1'b1;
        run_cmd(200, 'h3F00, 16384, 1'b1, 32'hFFFF0000, 0, dc);
        check32(32'(dc), 32'(VERIFY ? 2 * 16384 + 2 : 16384 + 1), "full range done cycle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nios_core_mem_fill_master.md
# nios_core_mem_fill_master

Avalon-MM initiator that drives the single-port on-chip memory slave (14-bit word address, 32-bit data, 4-bit byteenable, 1-cycle read latency) from the memory side's opposite end. On a start command it writes a generated pattern over a word range, then optionally reads it back and compares. It sits beside the Nios core as a boot-time memory initializer and self-test engine, muxed onto the memory's s2 port.

## Interface
Parameters:
- ADDR_W, 14, word address width (16384 words)
- DATA_W, 32, data width; byteenable is DATA_W/8

Ports (single clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- start  in  1  command strobe, sampled only in IDLE
- base_addr  in  14  first word address
- word_count  in  15  words to process, 0..16384
- pattern_mode  in  1  0 = constant seed, 1 = seed + word index
- seed  in  32  pattern seed
- mem_address  out  14  to memory address
- mem_byteenable  out  4  always 4'hF when chipselect high, else 0
- mem_chipselect  out  1  access valid
- mem_write  out  1  1 = write, 0 = read
- mem_writedata  out  32  write data
- mem_clken  out  1  memory clock enable, 1 except during reset
- mem_readdata  in  32  memory read data, valid 1 cycle after read address
- busy  out  1  command in progress
- done  out  1  1-cycle completion pulse
- error  out  1  sticky mismatch flag, cleared by next accepted start
- err_addr  out  14  address of first mismatch
- err_data  out  32  data read at first mismatch

## Operation
- States: IDLE, WRITE, READ, CHECK, DONE.
- IDLE: start=1 latches base_addr, word_count, pattern_mode, seed; clears error/err_addr/err_data; index←0. word_count=0 → DONE directly, no memory access.
- WRITE: one write per cycle at address (base_addr+index) mod 2^14, data = seed (mode 0) or seed+index mod 2^32 (mode 1). After index=word_count−1 → READ (verify built) or DONE.
- READ: one read per cycle, same address/index sequence; each returned word compared one cycle later against the regenerated expected value. After last read → CHECK.
- CHECK: final compare, no access → DONE.
- DONE: done=1 for one cycle, → IDLE.
- Mismatch: first one captures err_addr/err_data and sets error; later mismatches ignored; scan continues to completion.
- start outside IDLE ignored. Address range wrap past 16383 to 0 is legal.
- Reset (any time, including mid-command): immediately IDLE, all outputs 0 except mem_clken (0 while reset asserted, 1 after); in-flight command abandoned, no done.

## Timing
- start sampled at edge 0; first access presented in cycle 1; all memory outputs registered.
- Writes cycles 1..N; reads N+1..2N; compares N+2..2N+1; done in cycle 2N+2 (verify) or N+1 (no verify); N=0 → done in cycle 1.
- busy high from cycle 1 through the done cycle inclusive; next start accepted the cycle after done.
- Reads back-to-back, no bubbles; compare of read k uses mem_readdata in the cycle after read k's address.

## Configuration
- NIOS_CORE_MEM_FILL_VERIFY_EN defined: READ and CHECK states, comparator and error capture built.
- Undefined: WRITE goes straight to DONE; error, err_addr, err_data tied 0; mem_readdata unused.

## Structure
- Package nios_core_mem_fill_pkg: state enum, ADDR_W/DATA_W defaults, PATTERN_CONST/PATTERN_INCR constants.
- Sub-module nios_core_mem_fill_pattern: combinational pattern generator (seed, index, mode → word), instanced once for write data and once for expected data.

## Test plan
- base 0x0000, count 4, mode 1, seed 0x100, verify on -> writes 0x100..0x103 at 0..3, reads 0..3, done in cycle 10, error 0.
- base 0x3FFE, count 4, mode 0, seed 0xA5A5A5A5 -> addresses 0x3FFE,0x3FFF,0x0000,0x0001, done pulse, error 0.
- Memory model corrupts word at 0x0012 to 0xDEADBEEF, base 0x10 count 8 -> error 1, err_addr 0x0012, err_data 0xDEADBEEF; second corruption at 0x0014 does not overwrite.
- count 0 -> no chipselect ever, busy/done high in cycle 1 only.
- start pulsed mid-WRITE -> ignored; reset asserted mid-READ -> outputs 0 next edge, no done, new start works normally.
- Verify compiled out, count 3 -> three writes, done in cycle 4, error stays 0.
